// File: rtl/hash_msg_pkg.sv
// Shared types and constants for the hash message buffer: padding FSM states,
// message-length field geometry and the padding marker word.
package hash_msg_pkg;

   typedef enum logic [2:0] {
      PAD_IDLE,
      PAD_ONE,
      PAD_ZERO,
      PAD_LEN,
      PAD_DONE
   } pad_state_t;

   localparam int LEN_BITS = 64;

   function automatic int len_words(input int word_w);
      return LEN_BITS / word_w;
   endfunction

   // Marker word with only the MSB of a word_w-bit word set; callers truncate to word_w.
   function automatic logic [LEN_BITS-1:0] pad_marker(input int word_w);
      return 64'd1 << (word_w - 1);
   endfunction

endpackage

// File: rtl/hash_msg_ram.sv
// Circular word store with one write port, an asynchronous read port and
// free-running wrap-around pointers. Callers pass already-qualified strobes.
module hash_msg_ram
   import hash_msg_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic              i_wr_en,
   input  logic [WORD_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   output logic [WORD_W-1:0] o_rd_data
);

   localparam int AW = $clog2(DEPTH);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset so it maps onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/hash_msg_fifo.sv
// Block-granular message buffer in front of a hash core: stores bus words,
// releases only complete blocks and optionally appends SHA-256 style padding.
module hash_msg_fifo
   import hash_msg_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter int BLK_WORDS = 16,
   parameter int DEPTH     = 64,
   parameter int PAD_EN    = 1
) (
   input  logic                     clk_100mhz,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     wr_en_i,
   input  logic [WORD_W-1:0]        wr_data_i,
   input  logic                     fin_i,
   output logic                     full_o,
   output logic                     err_o,
   output logic [$clog2(DEPTH):0]   fill_o,
   output logic                     blk_avail_o,
   output logic                     rd_valid_o,
   input  logic                     rd_ready_i,
   output logic [WORD_W-1:0]        rd_data_o,
   output logic                     rd_last_o,
   output logic [LEN_BITS-1:0]      msg_bits_o,
   output logic                     pad_busy_o,
   output logic                     pad_done_o
);

   localparam int FW        = $clog2(DEPTH) + 1;
   localparam int PW        = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
   localparam int LEN_WORDS = len_words(WORD_W);
   localparam int LW        = (LEN_WORDS > 1) ? $clog2(LEN_WORDS) : 1;
   localparam logic [PW-1:0]     POS_LAST = PW'(BLK_WORDS - 1);
   localparam logic [LW-1:0]     LEN_LAST = LW'(LEN_WORDS - 1);
   localparam logic [WORD_W-1:0] MARKER   = WORD_W'(pad_marker(WORD_W));

   pad_state_t          r_state, w_state_nxt;
   logic [FW-1:0]       r_fill, r_blk_cnt;
   logic [PW-1:0]       r_wr_pos, r_rd_pos;
   logic [LEN_BITS-1:0] r_msg_bits, r_len;
   logic [LW-1:0]       r_len_idx;
   logic                r_err;

   logic                w_full, w_pad_wr, w_data_req, w_wr_fire, w_data_fire, w_drop;
   logic                w_rd_valid, w_rd_fire, w_pos_wrap, w_rd_last, w_fin_take, w_len_slot;
   logic [WORD_W-1:0]   w_wr_word, w_len_word, w_ram_data;

   assign w_full      = (r_fill == FW'(DEPTH));
   assign w_pad_wr    = (r_state == PAD_ONE) || (r_state == PAD_ZERO) || (r_state == PAD_LEN);
   assign w_data_req  = wr_en_i && (r_state == PAD_IDLE);
   assign w_wr_fire   = (w_data_req || w_pad_wr) && !w_full && !clr_i;
   assign w_data_fire = w_data_req && w_wr_fire;
   assign w_drop      = wr_en_i && !clr_i && ((r_state != PAD_IDLE) || w_full);
   assign w_rd_valid  = (r_blk_cnt != '0);
   assign w_rd_fire   = w_rd_valid && rd_ready_i && !clr_i;
   assign w_pos_wrap  = (r_wr_pos == POS_LAST);
   assign w_rd_last   = (r_rd_pos == POS_LAST);
   assign w_fin_take  = (PAD_EN != 0) && fin_i && (r_state == PAD_IDLE) && !clr_i;
   // True when the word now being written is the last one before the length field.
   assign w_len_slot  = (int'(r_wr_pos) + 1 == BLK_WORDS - LEN_WORDS);
   assign w_len_word  = WORD_W'(r_len >> (WORD_W * (LEN_WORDS - 1 - int'(r_len_idx))));

   always_comb begin
      w_state_nxt = r_state;
      w_wr_word   = wr_data_i;
      unique case (r_state)
         PAD_IDLE: if (w_fin_take) w_state_nxt = PAD_ONE;
         PAD_ONE: begin
            w_wr_word = MARKER;
            if (w_wr_fire) w_state_nxt = w_len_slot ? PAD_LEN : PAD_ZERO;
         end
         PAD_ZERO: begin
            w_wr_word = '0;
            if (w_wr_fire && w_len_slot) w_state_nxt = PAD_LEN;
         end
         PAD_LEN: begin
            w_wr_word = w_len_word;
            if (w_wr_fire && (r_len_idx == LEN_LAST)) w_state_nxt = PAD_DONE;
         end
         PAD_DONE: w_state_nxt = PAD_IDLE;
         default:  w_state_nxt = PAD_IDLE;
      endcase
   end

   always_ff @(posedge clk_100mhz or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= PAD_IDLE;
         r_fill     <= '0;
         r_blk_cnt  <= '0;
         r_wr_pos   <= '0;
         r_rd_pos   <= '0;
         r_msg_bits <= '0;
         r_len      <= '0;
         r_len_idx  <= '0;
         r_err      <= 1'b0;
      end else if (clr_i) begin
         r_state    <= PAD_IDLE;
         r_fill     <= '0;
         r_blk_cnt  <= '0;
         r_wr_pos   <= '0;
         r_rd_pos   <= '0;
         r_msg_bits <= '0;
         r_len      <= '0;
         r_len_idx  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fill  <= r_fill + FW'(w_wr_fire) - FW'(w_rd_fire);
         if (w_wr_fire) r_wr_pos <= w_pos_wrap ? '0 : r_wr_pos + 1'b1;
         if (w_rd_fire) r_rd_pos <= w_rd_last ? '0 : r_rd_pos + 1'b1;
         // Completing and draining a block in the same cycle cancel out.
         unique case ({w_wr_fire && w_pos_wrap, w_rd_fire && w_rd_last})
            2'b10:   r_blk_cnt <= r_blk_cnt + 1'b1;
            2'b01:   r_blk_cnt <= r_blk_cnt - 1'b1;
            default: r_blk_cnt <= r_blk_cnt;
         endcase
         if (w_drop) r_err <= 1'b1;
         if (r_state == PAD_DONE) r_msg_bits <= '0;
         else if (w_data_fire)    r_msg_bits <= r_msg_bits + LEN_BITS'(WORD_W);
         // A data word accepted alongside fin_i belongs to the message length.
         if (w_fin_take) begin
            r_len     <= r_msg_bits + (w_data_fire ? LEN_BITS'(WORD_W) : '0);
            r_len_idx <= '0;
         end else if ((r_state == PAD_LEN) && w_wr_fire) begin
            r_len_idx <= r_len_idx + 1'b1;
         end
      end
   end

   hash_msg_ram #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .i_clk     (clk_100mhz),
      .i_rst     (rst_i),
      .i_clr     (clr_i),
      .i_wr_en   (w_wr_fire),
      .i_wr_data (w_wr_word),
      .i_rd_en   (w_rd_fire),
      .o_rd_data (w_ram_data)
   );

   assign full_o      = w_full;
   assign err_o       = r_err;
   assign fill_o      = r_fill;
   assign blk_avail_o = w_rd_valid;
   assign rd_valid_o  = w_rd_valid;
   assign rd_data_o   = w_rd_valid ? w_ram_data : '0;
   assign rd_last_o   = w_rd_valid && w_rd_last;
   assign msg_bits_o  = r_msg_bits;
   assign pad_busy_o  = w_pad_wr;
   assign pad_done_o  = (r_state == PAD_DONE);

endmodule

// File: tb/tb_hash_msg_fifo.sv
// Directed bench for hash_msg_fifo (WORD_W=32, BLK_WORDS=16, DEPTH=32) with
// hand-computed expected words held in a scoreboard queue.
module tb_hash_msg_fifo;

   localparam int WORD_W = 32;
   localparam int BLK    = 16;
   localparam int DEPTH  = 32;
   localparam int FW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clr = 1'b0;
   logic              wr_en = 1'b0;
   logic [WORD_W-1:0] wr_data = '0;
   logic              fin = 1'b0;
   logic              rd_ready = 1'b0;
   logic              full, err, blk_avail, rd_valid, rd_last, pad_busy, pad_done;
   logic [FW-1:0]     fill;
   logic [WORD_W-1:0] rd_data;
   logic [63:0]       msg_bits;

   int n_checks = 0;
   int n_errors = 0;
   logic [WORD_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   hash_msg_fifo #(
      .WORD_W    (WORD_W),
      .BLK_WORDS (BLK),
      .DEPTH     (DEPTH),
      .PAD_EN    (1)
   ) dut (
      .clk_100mhz  (clk),
      .rst_i       (rst),
      .clr_i       (clr),
      .wr_en_i     (wr_en),
      .wr_data_i   (wr_data),
      .fin_i       (fin),
      .full_o      (full),
      .err_o       (err),
      .fill_o      (fill),
      .blk_avail_o (blk_avail),
      .rd_valid_o  (rd_valid),
      .rd_ready_i  (rd_ready),
      .rd_data_o   (rd_data),
      .rd_last_o   (rd_last),
      .msg_bits_o  (msg_bits),
      .pad_busy_o  (pad_busy),
      .pad_done_o  (pad_done)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [WORD_W-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_full"}, full, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_fill"}, fill, 0);
      check({tag, "_blk_avail"}, blk_avail, 0);
      check({tag, "_rd_valid"}, rd_valid, 0);
      check({tag, "_rd_data"}, rd_data, 0);
      check({tag, "_rd_last"}, rd_last, 0);
      check({tag, "_msg_bits"}, msg_bits, 0);
      check({tag, "_pad_busy"}, pad_busy, 0);
      check({tag, "_pad_done"}, pad_done, 0);
   endtask

   task automatic run_pad(input string tag);
      int pulses;
      pulses = 0;
      fin = 1'b1;
      tick();
      fin = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (pad_done) pulses++;
      end
      check({tag, "_done_pulses"}, pulses, 1);
      check({tag, "_busy_after"}, pad_busy, 0);
   endtask

   task automatic drain(input int n, input int start_idx, input string tag);
      int waited;
      logic [WORD_W-1:0] exp;
      rd_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         waited = 0;
         while (!rd_valid && waited < 20) begin
            tick();
            waited++;
         end
         if (!rd_valid) begin
            check({tag, "_valid_timeout"}, 0, 1);
            rd_ready = 1'b0;
            return;
         end
         exp = exp_q.pop_front();
         check({tag, "_data"}, rd_data, exp);
         check({tag, "_last"}, rd_last, ((start_idx + i) % BLK) == (BLK - 1));
         tick();
      end
      rd_ready = 1'b0;
   endtask

   task automatic push_empty_pad();
      exp_q.push_back(32'h8000_0000);
      for (int i = 0; i < 15; i++) exp_q.push_back(32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WORD_W-1:0] b_word;
      logic              ready_pat [3];
      ready_pat[0] = 1'b1;
      ready_pat[1] = 1'b0;
      ready_pat[2] = 1'b1;

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check_all_zero("post_reset");

      // 1: empty message padding
      run_pad("t1");
      check("t1_blk_avail", blk_avail, 1);
      check("t1_fill", fill, 16);
      check("t1_msg_bits", msg_bits, 0);
      push_empty_pad();
      drain(16, 0, "t1");
      check("t1_fill_end", fill, 0);
      check("t1_valid_end", rd_valid, 0);

      // 2: 14 data words then padding spilling into a second block
      for (int i = 0; i < 14; i++) begin
         write_word(32'h1111_1111);
         exp_q.push_back(32'h1111_1111);
      end
      check("t2_msg_bits", msg_bits, 448);
      run_pad("t2");
      check("t2_fill", fill, 32);
      check("t2_full", full, 1);
      check("t2_err", err, 0);
      check("t2_msg_bits_clr", msg_bits, 0);
      exp_q.push_back(32'h8000_0000);
      exp_q.push_back(32'h0);
      for (int i = 0; i < 14; i++) exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000_01C0);
      drain(32, 0, "t2");
      check("t2_fill_end", fill, 0);

      // 3: partial block is withheld
      for (int i = 0; i < 15; i++) begin
         write_word(32'hA5A5_0000 + i);
         exp_q.push_back(32'hA5A5_0000 + i);
      end
      check("t3_valid_partial", rd_valid, 0);
      check("t3_fill_partial", fill, 15);
      check("t3_blk_avail_partial", blk_avail, 0);
      write_word(32'hA5A5_000F);
      exp_q.push_back(32'hA5A5_000F);
      check("t3_valid_full_blk", rd_valid, 1);
      check("t3_msg_bits", msg_bits, 512);

      // 5: backpressure with concurrent writes into the next block
      for (int k = 0; k < 3; k++) begin
         b_word   = 32'hB0B0_0000 + k;
         wr_en    = 1'b1;
         wr_data  = b_word;
         rd_ready = ready_pat[k];
         check("t5_bp_data", rd_data, exp_q[0]);
         check("t5_bp_last", rd_last, 0);
         exp_q.push_back(b_word);
         if (ready_pat[k]) void'(exp_q.pop_front());
         tick();
      end
      wr_en    = 1'b0;
      rd_ready = 1'b0;
      check("t5_fill", fill, 17);
      for (int k = 3; k < 16; k++) begin
         write_word(32'hB0B0_0000 + k);
         exp_q.push_back(32'hB0B0_0000 + k);
      end
      check("t5_msg_bits", msg_bits, 1024);
      check("t5_fill_two_blk", fill, 30);
      drain(30, 2, "t5");

      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_msg_bits", msg_bits, 0);
      check("clr_fill", fill, 0);

      // 4: overflow drops the write and latches err
      for (int i = 0; i < 32; i++) write_word(32'hC0DE_0000 + i);
      check("t4_full", full, 1);
      check("t4_fill32", fill, 32);
      check("t4_err_before", err, 0);
      write_word(32'hDEAD_BEEF);
      check("t4_err", err, 1);
      check("t4_fill_after_drop", fill, 32);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t4_clr_fill", fill, 0);
      check("t4_clr_err", err, 0);
      check("t4_clr_full", full, 0);
      check("t4_clr_blk_avail", blk_avail, 0);

      // 6: asynchronous reset mid-padding, then a clean empty message
      for (int i = 0; i < 14; i++) write_word(32'h1111_1111);
      fin = 1'b1;
      tick();
      fin = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("t6_busy", pad_busy, 1);
      write_word(32'h2222_2222);
      check("t6_err_pad_write", err, 1);
      rst = 1'b1;
      #1;
      check_all_zero("t6_async_rst");
      tick();
      rst = 1'b0;
      tick();
      exp_q.delete();
      run_pad("t6");
      check("t6_fill", fill, 16);
      check("t6_blk_avail", blk_avail, 1);
      push_empty_pad();
      drain(16, 0, "t6");
      check("t6_fill_end", fill, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hash_msg_fifo.md
Name: hash_msg_fifo

Overview:
Parametrised message buffer between the register-bank FIFO write port and a block-oriented hash core (SHA-256 now, Keccak later). Accepts single data words from the bus and stores them in a word FIFO of configurable depth. Releases words to the core only in complete blocks. On request, appends SHA-256-style padding in hardware: a 1-bit marker, zero words, and the 64-bit message bit length.

Parameters:
WORD_W, 32, data word width; legal values 32 or 64.
BLK_WORDS, 16, words per hash block; must be at least 64/WORD_W+2.
DEPTH, 64, FIFO depth in words; power of 2, at least 2*BLK_WORDS.
PAD_EN, 1, 1 enables the fin_i padding engine; 0 ties pad logic off and fin_i is ignored.

Ports:
clk_100mhz  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
clr_i  in  1  synchronous flush of FIFO, counters and FSM
wr_en_i  in  1  data word write strobe
wr_data_i  in  WORD_W  data word
fin_i  in  1  pulse: message complete, start padding
full_o  out  1  FIFO full
err_o  out  1  sticky: write dropped (full, or during padding)
fill_o  out  $clog2(DEPTH)+1  words stored
blk_avail_o  out  1  at least one complete block stored
rd_valid_o  out  1  read word valid
rd_ready_i  in  1  consumer accepts word
rd_data_o  out  WORD_W  read word, first-word-fall-through
rd_last_o  out  1  rd_data_o is the last word of a block
msg_bits_o  out  64  accepted data bits, excluding padding
pad_busy_o  out  1  padding FSM active
pad_done_o  out  1  one-cycle pulse when the last length word is written

Behaviour:
- Reset (rst_i) values: all outputs 0; pointers, fill, blk_cnt, wr_pos, msg_bits = 0; FSM = IDLE.
- clr_i has the same effect as reset but is synchronous, and it takes priority over all other inputs in that cycle.
- Storage is a circular buffer of DEPTH words. Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Write acceptance: a write is accepted when its source strobes, !full_o holds, and there is no clr_i.
  - Data writes are accepted only in IDLE.
  - A dropped data write sets err_o; err_o is cleared only by rst_i or clr_i.
  - A full FIFO rejects writes even when a read occurs in the same cycle.
  - fill_o is updated one cycle after the write edge.
- wr_pos counts words within the current block, 0..BLK_WORDS-1. It increments on every accepted write, data or padding.
- When wr_pos wraps from BLK_WORDS-1 to 0, blk_cnt increments.
- A read handshake is rd_valid_o && rd_ready_i. A handshake with rd_last_o high decrements blk_cnt.
- If a block is completed and drained in the same cycle, blk_cnt is unchanged.
- rd_valid_o = (blk_cnt != 0). A partial block is never presented to the core.
- rd_last_o is high when the read-side word index equals BLK_WORDS-1.
- rd_data_o is mem[rd_ptr] and is stable while rd_valid_o && !rd_ready_i.
- blk_avail_o = (blk_cnt != 0); it reflects the registered blk_cnt.
- msg_bits_o adds WORD_W on each accepted data write, modulo 2^64.
- Padding FSM (PAD_EN=1). States IDLE, ONE, ZERO, LEN, DONE:
  - IDLE: fin_i -> ONE. A fin_i received while not in IDLE is ignored.
  - ONE: writes a word with only the MSB set (0x80000000 for WORD_W=32).
    - Next state is LEN if wr_pos+1 == BLK_WORDS-LEN_WORDS, else ZERO.
    - LEN_WORDS = 64/WORD_W.
  - ZERO: writes zero words until wr_pos == BLK_WORDS-LEN_WORDS, then -> LEN. This state spills into the next block when needed.
  - LEN: writes msg_bits latched on fin_i, MSW first, over LEN_WORDS writes. After the last write: pad_done_o pulses and the FSM -> DONE.
  - DONE -> IDLE in the next cycle; msg_bits clears to 0 on that transition.
  - pad_busy_o is high in ONE, ZERO and LEN.
  - FSM writes wait while full_o and resume without loss.
- A data write and fin_i in the same cycle: the data word is accepted first and counted, then padding starts in the next cycle.
- Reset or clr_i during padding aborts to IDLE with the buffer empty.

Decomposition:
- Package hash_msg_pkg holds:
  - pad_state_t enum;
  - LEN_BITS=64;
  - function len_words(WORD_W);
  - pad marker constant generation.
- Sub-module hash_msg_ram: a DEPTH×WORD_W storage array with one write port and an asynchronous read port, plus pointer logic.
- The padding FSM and block counting stay in the top module.

Test Plan:
1. Empty message (WORD_W=32, BLK_WORDS=16): fin_i -> 16 words: 0x80000000, 14×0x00000000, 0x00000000. msg_bits was 0, so the final word is 0. pad_done_o pulses once, blk_avail_o=1, rd_last_o is high on word 15.
2. 14 data words 0x11111111, then fin_i -> 32 words read. Block 1: 14×data, 0x80000000, 0. Block 2: 14×0, then 0x00000000, 0x000001C0 (448). Two rd_last_o pulses.
3. 15 data words with no fin_i -> rd_valid_o stays 0 and fill_o=15. The 16th word raises rd_valid_o next cycle; msg_bits_o=512.
4. DEPTH=32: 33 writes with rd_ready_i=0 -> full_o=1 after 32, the 33rd is dropped, err_o=1, fill_o=32. clr_i -> fill_o=0, err_o=0.
5. Backpressure: after 16 words, toggle rd_ready_i 1,0,1 -> rd_data_o is held during the low cycle and data order is preserved. A simultaneous write continues to fill the next block.
6. Assert rst_i during the ZERO state of scenario 2 -> all outputs 0 immediately. After release, scenario 1 produces the exact result of test 1.
